// File: rtl/vga_scan_timing_if.sv
// ---------------------------------------------------------------------------
// vga_scan_timing_if
//
// Bundle between the raster timing generator and the pixel colour logic /
// VGA pin driver.
//
//   pix_ce      pixel clock enable (into the generator)
//   rgb_in      12-bit {r,g,b} colour for the current draw_x/draw_y
//   draw_x      horizontal counter, 0..H_TOT-1
//   draw_y      vertical counter,   0..V_TOT-1
//   active      current counter position lies in the visible area
//   vga_r/g/b   registered pin colour, 4 bits each
//   vga_hs/vs   registered sync pins
//   frame_tick  one pix_ce-qualified cycle per frame, at start of vblank
//   frame_cnt   frames completed, wraps at 16 bits
//
// master: the timing generator.  slave: the colour logic / board side.
// ---------------------------------------------------------------------------
interface vga_scan_timing_if;
    logic        pix_ce;
    logic [11:0] rgb_in;
    logic [10:0] draw_x;
    logic [9:0]  draw_y;
    logic        active;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        frame_tick;
    logic [15:0] frame_cnt;

    modport master (
        input  pix_ce,
        input  rgb_in,
        output draw_x,
        output draw_y,
        output active,
        output vga_r,
        output vga_g,
        output vga_b,
        output vga_hs,
        output vga_vs,
        output frame_tick,
        output frame_cnt
    );

    modport slave (
        output pix_ce,
        output rgb_in,
        input  draw_x,
        input  draw_y,
        input  active,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  vga_hs,
        input  vga_vs,
        input  frame_tick,
        input  frame_cnt
    );
endinterface

// File: rtl/vga_scan_timing.sv
// ---------------------------------------------------------------------------
// vga_scan_timing
//
// Raster timing generator and pixel output stage.  Two stages:
//   p0 : draw_x/draw_y counters (exposed directly) and the combinational
//        'active' flag; the colour logic answers with rgb_in for this spot.
//   p1 : pin registers - blanked colour, hsync, vsync, frame tick/counter.
// Colour and both syncs go through the same single p1 register, so the
// pins stay aligned and lag the counters by exactly one pix_ce cycle.
//
// Ports:
//   clk    pixel / system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    vga_scan_timing_if.master (see interface file for signal list)
// ---------------------------------------------------------------------------
module vga_scan_timing #(
    parameter int unsigned H_VIS  = 1280,
    parameter int unsigned H_FP   = 72,
    parameter int unsigned H_SYNC = 128,
    parameter int unsigned H_BP   = 200,
    parameter int unsigned V_VIS  = 800,
    parameter int unsigned V_FP   = 3,
    parameter int unsigned V_SYNC = 6,
    parameter int unsigned V_BP   = 22,
    parameter bit          HS_POL = 1'b0,
    parameter bit          VS_POL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_scan_timing_if.master bus
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    // Boundaries pre-sized to the counter widths so every compare is
    // unsigned and width-matched.
    localparam logic [10:0] X_LAST     = 11'(H_TOT - 1);
    localparam logic [10:0] X_VIS      = 11'(H_VIS);
    localparam logic [10:0] X_HS_START = 11'(H_VIS + H_FP);
    localparam logic [10:0] X_HS_END   = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  Y_LAST     = 10'(V_TOT - 1);
    localparam logic [9:0]  Y_VIS      = 10'(V_VIS);
    localparam logic [9:0]  Y_VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0]  Y_VS_END   = 10'(V_VIS + V_FP + V_SYNC);

    // Sync level for a given counter position.
    function automatic logic hsync_level(input logic [10:0] x);
        return ((x >= X_HS_START) && (x < X_HS_END)) ? HS_POL : ~HS_POL;
    endfunction

    function automatic logic vsync_level(input logic [9:0] y);
        return ((y >= Y_VS_START) && (y < Y_VS_END)) ? VS_POL : ~VS_POL;
    endfunction

    // Colour forced to black outside the visible area.
    function automatic logic [11:0] blank_rgb(input logic vis, input logic [11:0] rgb);
        return vis ? rgb : 12'h000;
    endfunction

    // ---- stage p0: raster counters ----------------------------------------
    logic [10:0] x_p0;
    logic [9:0]  y_p0;
    logic        vld_p0;
    logic        line_end_p0;
    logic        frame_end_p0;
    logic        vblank_start_p0;

    always_comb begin
        line_end_p0     = (x_p0 == X_LAST);
        frame_end_p0    = (y_p0 == Y_LAST);
        vld_p0          = (x_p0 < X_VIS) && (y_p0 < Y_VIS);
        vblank_start_p0 = (x_p0 == 11'd0) && (y_p0 == Y_VIS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_p0 <= 11'd0;
            y_p0 <= 10'd0;
        end else if (bus.pix_ce) begin
            if (line_end_p0) begin
                x_p0 <= 11'd0;
                // Bottom-right corner: both counters wrap on the same edge.
                y_p0 <= frame_end_p0 ? 10'd0 : y_p0 + 10'd1;
            end else begin
                x_p0 <= x_p0 + 11'd1;
            end
        end
    end

    // ---- stage p1: pin registers ------------------------------------------
    logic [11:0] rgb_p1;
    logic        hs_p1;
    logic        vs_p1;
    logic        tick_p1;
    logic [15:0] frame_cnt_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_p1       <= 12'h000;
            hs_p1        <= ~HS_POL;
            vs_p1        <= ~VS_POL;
            tick_p1      <= 1'b0;
            frame_cnt_p1 <= 16'd0;
        end else if (bus.pix_ce) begin
            rgb_p1  <= blank_rgb(vld_p0, bus.rgb_in);
            hs_p1   <= hsync_level(x_p0);
            vs_p1   <= vsync_level(y_p0);
            // The counters leave (0, V_VIS) on this same edge, so the tick
            // can only fire once per frame even when pix_ce has gaps.
            tick_p1 <= vblank_start_p0;
            if (vblank_start_p0) begin
                frame_cnt_p1 <= frame_cnt_p1 + 16'd1;
            end
        end else begin
            // Strobe is one clock wide regardless of pix_ce duty.
            tick_p1 <= 1'b0;
        end
    end

    assign bus.draw_x     = x_p0;
    assign bus.draw_y     = y_p0;
    assign bus.active     = vld_p0;
    assign bus.vga_r      = rgb_p1[11:8];
    assign bus.vga_g      = rgb_p1[7:4];
    assign bus.vga_b      = rgb_p1[3:0];
    assign bus.vga_hs     = hs_p1;
    assign bus.vga_vs     = vs_p1;
    assign bus.frame_tick = tick_p1;
    assign bus.frame_cnt  = frame_cnt_p1;

endmodule
